// File: rtl/mem_access_arbiter.sv
// Shared-memory access controller: arbitrates NUM_PORTS requesters onto one
// fixed-latency memory and stalls each requester until its access completes.
module mem_access_arbiter #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned ARB_MODE  = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           req_read,
    input  logic [NUM_PORTS-1:0]           req_write,
    input  logic [NUM_PORTS*WORD_SIZE-1:0] req_addr,
    input  logic [NUM_PORTS*WORD_SIZE-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]           stall,
    output logic [NUM_PORTS-1:0]           done,
    output logic [WORD_SIZE-1:0]           rdata,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [WORD_SIZE-1:0]           mem_addr,
    output logic [WORD_SIZE-1:0]           mem_wdata,
    input  logic [WORD_SIZE-1:0]           mem_rdata,
    output logic [WORD_SIZE-1:0]           busy_cycles
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 wr_q, wr_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0] busy_q, busy_d;

    logic [NUM_PORTS-1:0] req, elig;
    logic                 any_elig, grant;
    logic                 found_hi, found_lo;
    logic [IDX_W-1:0]     pick, pick_hi, pick_lo;
    logic                 sel_wr;
    logic [WORD_SIZE-1:0] sel_addr, sel_wdata;

    // Candidate selection; the port completing in DONE is excluded from re-arbitration
    always_comb begin
        req      = req_read | req_write;
        elig     = '0;
        pick     = '0;
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            elig[i] = req[i] & ~((state_q == ST_DONE) && (gnt_q == IDX_W'(i)));
        end
        any_elig = |elig;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                if (elig[i]) pick = IDX_W'(i);
            end
        end else begin
            // Round-robin: lowest index at/after the pointer, else lowest index overall
            for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
                if (elig[i] && (IDX_W'(i) >= rr_ptr_q)) begin
                    pick_hi  = IDX_W'(i);
                    found_hi = 1'b1;
                end
                if (elig[i] && (IDX_W'(i) < rr_ptr_q)) begin
                    pick_lo  = IDX_W'(i);
                    found_lo = 1'b1;
                end
            end
            pick = found_hi ? pick_hi : pick_lo;
        end
    end

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (pick == IDX_W'(i)) begin
                sel_wr    = req_write[i];
                sel_addr  = req_addr[i*WORD_SIZE +: WORD_SIZE];
                sel_wdata = req_wdata[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        grant    = 1'b0;
        case (state_q)
            ST_IDLE: grant = any_elig;
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant   = any_elig;
            end
            default: state_d = ST_IDLE;
        endcase
        if (grant) begin
            state_d  = (LATENCY == 0) ? ST_DONE : ST_BUSY;
            gnt_d    = pick;
            wr_d     = sel_wr;
            addr_d   = sel_addr;
            wdata_d  = sel_wdata;
            cnt_d    = CNT_W'(LATENCY);
            rr_ptr_d = (pick == IDX_W'(NUM_PORTS - 1)) ? '0 : pick + IDX_W'(1);
        end
        if ((state_q != ST_IDLE) && (busy_q != '1)) begin
            busy_d = busy_q + WORD_SIZE'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
        end
    end

    // Strobes and handshakes are gated by reset so an aborted access is invisible
    always_comb begin
        mem_read    = (state_q != ST_IDLE) && !wr_q && !reset;
        mem_write   = (state_q != ST_IDLE) && wr_q && !reset;
        rdata       = ((state_q == ST_DONE) && !wr_q && !reset) ? mem_rdata : '0;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        busy_cycles = busy_q;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            done[i]  = (state_q == ST_DONE) && (gnt_q == IDX_W'(i)) && !reset;
            stall[i] = req[i] && !reset && !((state_q == ST_DONE) && (gnt_q == IDX_W'(i)));
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench: three arbiter configurations (latency 2 fixed-priority,
// latency 0, and 3-port round-robin) checked cycle by cycle.
module tb_mem_access_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // A: NUM_PORTS=2, LATENCY=2, fixed priority
    logic [1:0]  a_req_read = '0, a_req_write = '0, a_stall, a_done;
    logic [31:0] a_req_addr = '0, a_req_wdata = '0;
    logic [15:0] a_rdata, a_mem_addr, a_mem_wdata, a_busy, a_mem_rdata = '0;
    logic        a_mem_read, a_mem_write;

    // B: NUM_PORTS=2, LATENCY=0
    logic [1:0]  b_req_read = '0, b_req_write = '0, b_stall, b_done;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic [15:0] b_rdata, b_mem_addr, b_mem_wdata, b_busy, b_mem_rdata = '0;
    logic        b_mem_read, b_mem_write;

    // C: NUM_PORTS=3, LATENCY=2, round-robin
    logic [2:0]  c_req_read = '0, c_req_write = '0, c_stall, c_done;
    logic [47:0] c_req_addr = '0, c_req_wdata = '0;
    logic [15:0] c_rdata, c_mem_addr, c_mem_wdata, c_busy, c_mem_rdata = '0;
    logic        c_mem_read, c_mem_write;

    mem_access_arbiter #(.WORD_SIZE(16), .NUM_PORTS(2), .LATENCY(2), .ARB_MODE(0)) dut_a (
        .clk(clk), .reset(reset), .req_read(a_req_read), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .stall(a_stall), .done(a_done),
        .rdata(a_rdata), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .busy_cycles(a_busy));

    mem_access_arbiter #(.WORD_SIZE(16), .NUM_PORTS(2), .LATENCY(0), .ARB_MODE(0)) dut_b (
        .clk(clk), .reset(reset), .req_read(b_req_read), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .stall(b_stall), .done(b_done),
        .rdata(b_rdata), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .busy_cycles(b_busy));

    mem_access_arbiter #(.WORD_SIZE(16), .NUM_PORTS(3), .LATENCY(2), .ARB_MODE(1)) dut_c (
        .clk(clk), .reset(reset), .req_read(c_req_read), .req_write(c_req_write),
        .req_addr(c_req_addr), .req_wdata(c_req_wdata), .stall(c_stall), .done(c_done),
        .rdata(c_rdata), .mem_read(c_mem_read), .mem_write(c_mem_write),
        .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata),
        .busy_cycles(c_busy));

    // Advance into the next cycle, just past the active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_req_read = 2'b01;
        step();
        #1;
        checks++; if (a_stall !== 2'b00) begin errors++; $display("FAIL rst_stall_forced: got %b want 00", a_stall); end
        checks++; if (a_done !== 2'b00) begin errors++; $display("FAIL rst_done_forced: got %b want 00", a_done); end
        checks++; if (a_mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read_forced: got %b want 0", a_mem_read); end
        a_req_read = 2'b00;
        reset = 1'b0;
        #1;
        checks++; if (a_busy !== 16'h0) begin errors++; $display("FAIL rst_busy: got %h want 0000", a_busy); end
        checks++; if (a_mem_addr !== 16'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0000", a_mem_addr); end
        checks++; if (a_mem_wdata !== 16'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0000", a_mem_wdata); end
        checks++; if (a_rdata !== 16'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0000", a_rdata); end
        checks++; if (b_mem_write !== 1'b0) begin errors++; $display("FAIL rst_b_mem_write: got %b want 0", b_mem_write); end
        checks++; if (c_done !== 3'b000) begin errors++; $display("FAIL rst_c_done: got %b want 000", c_done); end
    endtask

    task automatic test_single_read();
        logic [1:0] exp_stall, exp_done;
        step();
        a_mem_rdata = 16'hBEEF;
        a_req_addr[15:0] = 16'h0010;
        a_req_read = 2'b01;
        #1;
        checks++; if (a_stall !== 2'b01) begin errors++; $display("FAIL rd_stall_c0: got %b want 01", a_stall); end
        checks++; if (a_mem_read !== 1'b0) begin errors++; $display("FAIL rd_mem_read_c0: got %b want 0", a_mem_read); end
        for (int c = 1; c <= 3; c++) begin
            step();
            #1;
            exp_stall = (c < 3) ? 2'b01 : 2'b00;
            exp_done  = (c == 3) ? 2'b01 : 2'b00;
            checks++; if (a_stall !== exp_stall) begin errors++; $display("FAIL rd_stall_c%0d: got %b want %b", c, a_stall, exp_stall); end
            checks++; if (a_done !== exp_done) begin errors++; $display("FAIL rd_done_c%0d: got %b want %b", c, a_done, exp_done); end
            checks++; if (a_mem_read !== 1'b1) begin errors++; $display("FAIL rd_mem_read_c%0d: got %b want 1", c, a_mem_read); end
            checks++; if (a_mem_addr !== 16'h0010) begin errors++; $display("FAIL rd_mem_addr_c%0d: got %h want 0010", c, a_mem_addr); end
        end
        checks++; if (a_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_rdata: got %h want beef", a_rdata); end
        a_req_read = 2'b00;
        step();
        #1;
        checks++; if (a_done !== 2'b00) begin errors++; $display("FAIL rd_done_after: got %b want 00", a_done); end
        checks++; if (a_mem_read !== 1'b0) begin errors++; $display("FAIL rd_mem_read_after: got %b want 0", a_mem_read); end
        checks++; if (a_busy !== 16'd3) begin errors++; $display("FAIL rd_busy_cycles: got %0d want 3", a_busy); end
    endtask

    task automatic test_zero_latency();
        step();
        b_req_addr[31:16]  = 16'h0020;
        b_req_wdata[31:16] = 16'h1234;
        b_req_write = 2'b10;
        #1;
        checks++; if (b_stall !== 2'b10) begin errors++; $display("FAIL l0_stall_c0: got %b want 10", b_stall); end
        checks++; if (b_mem_write !== 1'b0) begin errors++; $display("FAIL l0_mem_write_c0: got %b want 0", b_mem_write); end
        checks++; if (b_done !== 2'b00) begin errors++; $display("FAIL l0_done_c0: got %b want 00", b_done); end
        step();
        #1;
        checks++; if (b_mem_write !== 1'b1) begin errors++; $display("FAIL l0_mem_write_c1: got %b want 1", b_mem_write); end
        checks++; if (b_mem_addr !== 16'h0020) begin errors++; $display("FAIL l0_mem_addr: got %h want 0020", b_mem_addr); end
        checks++; if (b_mem_wdata !== 16'h1234) begin errors++; $display("FAIL l0_mem_wdata: got %h want 1234", b_mem_wdata); end
        checks++; if (b_done !== 2'b10) begin errors++; $display("FAIL l0_done_c1: got %b want 10", b_done); end
        checks++; if (b_stall !== 2'b00) begin errors++; $display("FAIL l0_stall_c1: got %b want 00", b_stall); end
        checks++; if (b_rdata !== 16'h0) begin errors++; $display("FAIL l0_rdata: got %h want 0000", b_rdata); end
        b_req_write = 2'b00;
        step();
        #1;
        checks++; if (b_mem_write !== 1'b0) begin errors++; $display("FAIL l0_mem_write_c2: got %b want 0", b_mem_write); end
        checks++; if (b_done !== 2'b00) begin errors++; $display("FAIL l0_done_c2: got %b want 00", b_done); end
    endtask

    task automatic test_fixed_priority();
        logic [1:0] exp_done;
        logic       exp_rd;
        step();
        a_req_addr = {16'h0200, 16'h0100};
        a_req_read = 2'b11;
        #1;
        checks++; if (a_stall !== 2'b11) begin errors++; $display("FAIL fp_stall_c0: got %b want 11", a_stall); end
        for (int c = 1; c <= 7; c++) begin
            step();
            #1;
            exp_done = (c == 3) ? 2'b10 : ((c == 6) ? 2'b01 : 2'b00);
            exp_rd   = (c <= 6);
            checks++; if (a_done !== exp_done) begin errors++; $display("FAIL fp_done_c%0d: got %b want %b", c, a_done, exp_done); end
            checks++; if (a_mem_read !== exp_rd) begin errors++; $display("FAIL fp_mem_read_c%0d: got %b want %b", c, a_mem_read, exp_rd); end
            if (c == 1) begin
                checks++; if (a_mem_addr !== 16'h0200) begin errors++; $display("FAIL fp_addr_first: got %h want 0200", a_mem_addr); end
            end
            if (c == 3) begin
                checks++; if (a_stall !== 2'b01) begin errors++; $display("FAIL fp_stall_c3: got %b want 01", a_stall); end
                a_req_read[1] = 1'b0;
            end
            if (c == 4) begin
                checks++; if (a_mem_addr !== 16'h0100) begin errors++; $display("FAIL fp_addr_second: got %h want 0100", a_mem_addr); end
            end
            if (c == 6) a_req_read = 2'b00;
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_done;
        step();
        c_req_addr = {16'h0003, 16'h0002, 16'h0001};
        c_req_read = 3'b111;
        #1;
        for (int c = 1; c <= 12; c++) begin
            step();
            #1;
            exp_done = 3'b000;
            if (c % 3 == 0) exp_done = 3'b001 << ((c / 3 - 1) % 3);
            checks++; if (c_done !== exp_done) begin errors++; $display("FAIL rr_done_c%0d: got %b want %b", c, c_done, exp_done); end
            if (c == 7) begin
                checks++; if (c_mem_addr !== 16'h0003) begin errors++; $display("FAIL rr_addr_c7: got %h want 0003", c_mem_addr); end
            end
        end
        c_req_read = 3'b000;
    endtask

    task automatic test_reset_mid_access();
        logic [1:0] exp_done;
        step();
        a_req_addr[15:0] = 16'h0030;
        a_mem_rdata = 16'hCAFE;
        a_req_read = 2'b01;
        step();
        #1;
        checks++; if (a_mem_read !== 1'b1) begin errors++; $display("FAIL rm_mem_read_busy: got %b want 1", a_mem_read); end
        reset = 1'b1;
        #1;
        checks++; if (a_mem_read !== 1'b0) begin errors++; $display("FAIL rm_mem_read_in_reset: got %b want 0", a_mem_read); end
        checks++; if (a_done !== 2'b00) begin errors++; $display("FAIL rm_done_in_reset: got %b want 00", a_done); end
        checks++; if (a_stall !== 2'b00) begin errors++; $display("FAIL rm_stall_in_reset: got %b want 00", a_stall); end
        step();
        reset = 1'b0;
        #1;
        checks++; if (a_mem_read !== 1'b0) begin errors++; $display("FAIL rm_mem_read_idle: got %b want 0", a_mem_read); end
        checks++; if (a_busy !== 16'h0) begin errors++; $display("FAIL rm_busy_cleared: got %h want 0000", a_busy); end
        checks++; if (a_mem_addr !== 16'h0) begin errors++; $display("FAIL rm_addr_cleared: got %h want 0000", a_mem_addr); end
        checks++; if (a_stall !== 2'b01) begin errors++; $display("FAIL rm_stall_reissue: got %b want 01", a_stall); end
        for (int c = 3; c <= 5; c++) begin
            step();
            #1;
            exp_done = (c == 5) ? 2'b01 : 2'b00;
            checks++; if (a_done !== exp_done) begin errors++; $display("FAIL rm_done_c%0d: got %b want %b", c, a_done, exp_done); end
        end
        checks++; if (a_rdata !== 16'hCAFE) begin errors++; $display("FAIL rm_rdata: got %h want cafe", a_rdata); end
        a_req_read = 2'b00;
    endtask

    task automatic test_read_write_both();
        step();
        a_req_addr[15:0]  = 16'h0040;
        a_req_wdata[15:0] = 16'h5A5A;
        a_mem_rdata = 16'hBEEF;
        a_req_read  = 2'b01;
        a_req_write = 2'b01;
        for (int c = 1; c <= 3; c++) begin
            step();
            #1;
            checks++; if (a_mem_write !== 1'b1) begin errors++; $display("FAIL rw_mem_write_c%0d: got %b want 1", c, a_mem_write); end
            checks++; if (a_mem_read !== 1'b0) begin errors++; $display("FAIL rw_mem_read_c%0d: got %b want 0", c, a_mem_read); end
        end
        checks++; if (a_mem_wdata !== 16'h5A5A) begin errors++; $display("FAIL rw_mem_wdata: got %h want 5a5a", a_mem_wdata); end
        checks++; if (a_done !== 2'b01) begin errors++; $display("FAIL rw_done: got %b want 01", a_done); end
        checks++; if (a_rdata !== 16'h0) begin errors++; $display("FAIL rw_rdata: got %h want 0000", a_rdata); end
        a_req_read  = 2'b00;
        a_req_write = 2'b00;
        step();
        #1;
        checks++; if (a_mem_write !== 1'b0) begin errors++; $display("FAIL rw_mem_write_after: got %b want 0", a_mem_write); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_zero_latency();
        test_fixed_priority();
        test_round_robin();
        test_reset_mid_access();
        test_read_write_both();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
